unary_window_acc: RTL
=====================

UNARY_WINDOW_ACC -- requirements
Module: unary_window_acc

Interface
REQ-001 SHALL have parameter IWID, default 8: number of parallel unary bit lanes per cycle.
REQ-002 SHALL have parameter WINLOG, default 4: window length is 2^WINLOG enabled cycles.
REQ-003 SHALL have parameter OWID, default $clog2(IWID*2^WINLOG+1): output count width.
REQ-004 SHALL have port clk, input, 1: clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port iEn, input, 1: the cycle's iBits are valid and counted.
REQ-007 SHALL have port iBits, input, IWID: unary bitstream lanes, one bit per lane per cycle.
REQ-008 SHALL have port iClr, input, 1: synchronous abort of the current window.
REQ-009 SHALL have port oData, output, OWID: completed-window count, registered, held between windows.
REQ-010 SHALL have port oSel, output, 1: ping-pong select for the downstream double buffer, registered.
REQ-011 SHALL have port oDone, output, 1: one-cycle pulse coincident with each oSel toggle.

Function
REQ-012 SHALL use FSM states IDLE and ACC; IDLE->ACC on the first cycle with iEn=1; ACC->IDLE on iClr.
REQ-013 SHALL, per enabled cycle, add popcount(iBits) to the internal accumulator and increment the window counter (WINLOG bits).
REQ-014 SHALL, on a cycle with iEn=0, hold the accumulator and counter unchanged, with no partial output.
REQ-015 SHALL, on the enabled cycle where the counter equals 2^WINLOG-1, load oData with accumulator+popcount(iBits) at that edge (edge E) and clear the accumulator and counter; FSM stays in ACC.
REQ-016 SHALL toggle oSel and assert oDone at edge E+1, one cycle after oData updates, so the downstream buffer captures the stable new count before the select flips.
REQ-017 SHALL accept and count iBits during the E+1 cycle with no bubble; back-to-back windows are sustained.
REQ-018 SHALL hold oData and oSel constant at all times other than REQ-015/REQ-016 edges.
REQ-019 SHALL keep the accumulator wide enough to hold IWID*2^WINLOG without overflow.
REQ-020 SHALL, when OWID is smaller than required, saturate oData at 2^OWID-1; it SHALL NOT wrap.
REQ-021 SHALL, on iClr=1, clear the accumulator and counter and go to IDLE with iBits ignored that cycle; oData and oSel hold.
REQ-022 SHALL give iClr priority when it coincides with a window-final cycle: no oData load and no pending toggle from that cycle.
REQ-023 SHALL still complete an oSel toggle already pending from edge E, even if iClr is asserted in the E+1 cycle.
REQ-024 SHALL treat iBits as don't-care when iEn=0 and SHALL NOT let X on iBits propagate in that case.

Reset
REQ-025 SHALL, on rst_n low, asynchronously set oData=0, oSel=0, oDone=0, accumulator=0, counter=0, pending toggle=0 and state=IDLE.
REQ-026 SHALL, after rst_n deasserts mid-window, discard the partial window and start the next window at the first iEn=1.

Verification (IWID=4, WINLOG=2, OWID=5 unless stated)
REQ-027 SHALL cover post-reset values: oData=0, oSel=0 and oDone=0, all held with iEn=0 for 10 cycles.
REQ-028 SHALL cover iBits=4'b1111 with iEn=1 for 4 cycles: oData=16 at edge 4, then oSel=1 and oDone=1 at edge 5 only.
REQ-029 SHALL cover iBits=4'b0011 over 4 enabled cycles interleaved with 2 iEn=0 cycles: oData=8 after the 4th enabled cycle, with no earlier update.
REQ-030 SHALL cover 2 enabled cycles of 4'b1111, then iClr, then 4 cycles of 4'b0001: oData=4, not 12, with exactly one oSel toggle.
REQ-031 SHALL cover OWID=4 with 4 cycles of 4'b1111: oData saturates at 15.
REQ-032 SHALL cover 8 continuous enabled cycles of 4'b0101: oData=8 twice, oSel toggles 0->1->0, and oDone pulses twice, 4 cycles apart.

Source files
------------

// File: rtl/unary_window_acc.sv
// unary_window_acc
//   Counts the ones arriving on IWID parallel unary bit lanes over a window of
//   2^WINLOG enabled cycles. Each completed window count is published on oData.
//   One cycle later oSel toggles and oDone pulses, so a downstream double
//   buffer can capture the already-stable count before its select flips.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   iEn    : iBits valid this cycle; the cycle counts toward the window
//   iBits  : IWID unary lanes, one bit per lane per cycle
//   iClr   : synchronous abort of the current window
//   oData  : last completed-window count, saturated to OWID bits, held
//   oSel   : ping-pong select, toggles once per completed window
//   oDone  : one-cycle pulse coincident with each oSel toggle
module unary_window_acc #(
  parameter int IWID   = 8,
  parameter int WINLOG = 4,
  parameter int OWID   = $clog2(IWID * (2 ** WINLOG) + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iEn,
  input  logic [IWID-1:0] iBits,
  input  logic            iClr,
  output logic [OWID-1:0] oData,
  output logic            oSel,
  output logic            oDone
);

  // Holds a full window (IWID * 2^WINLOG) with no overflow.
  localparam int ACC_W = $clog2(IWID * (2 ** WINLOG) + 1);
  localparam int CMP_W = (ACC_W > OWID) ? ACC_W : OWID;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WINLOG-1:0]   cnt_q, cnt_d;
  logic [OWID-1:0]     data_q, data_d;
  logic                sel_q, sel_d;
  logic                done_q, done_d;
  logic                pend_q, pend_d;

  logic [IWID-1:0]     bits_gated;
  logic [ACC_W-1:0]    pop;
  logic [ACC_W-1:0]    win_sum;

  function automatic logic [ACC_W-1:0] popcount(input logic [IWID-1:0] b);
    logic [ACC_W-1:0] n;
    n = '0;
    for (int i = 0; i < IWID; i++) begin
      n = n + ACC_W'(b[i]);
    end
    return n;
  endfunction

  // Clamp to the all-ones OWID value instead of wrapping when OWID is narrow.
  function automatic logic [OWID-1:0] sat_out(input logic [ACC_W-1:0] v);
    logic [CMP_W-1:0] vw;
    logic [CMP_W-1:0] maxw;
    vw   = CMP_W'(v);
    maxw = CMP_W'({OWID{1'b1}});
    if (vw > maxw) begin
      return OWID'(maxw);
    end
    return OWID'(vw);
  endfunction

  // Masking with iEn keeps unknown lanes on idle cycles out of the sum.
  assign bits_gated = iBits & {IWID{iEn}};
  assign pop        = popcount(bits_gated);
  assign win_sum    = acc_q + pop;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pend_d  = 1'b0;
    // A toggle scheduled at the window-final edge completes one edge later,
    // regardless of iClr in that following cycle.
    sel_d   = sel_q ^ pend_q;
    done_d  = pend_q;

    if (iClr) begin
      // Abort wins over everything, including a window-final cycle.
      acc_d   = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else if (iEn) begin
      state_d = ACC;
      if (cnt_q == {WINLOG{1'b1}}) begin
        data_d = sat_out(win_sum);
        acc_d  = '0;
        cnt_d  = '0;
        pend_d = 1'b1;
      end else begin
        acc_d = win_sum;
        cnt_d = cnt_q + WINLOG'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign oData = data_q;
  assign oSel  = sel_q;
  assign oDone = done_q;

endmodule
